reg_spad_acc_mp: RTL and testbench
==================================

// Module: reg_spad_acc_mp
// PURPOSE
//  Next-generation PE scratch pad: NUM_REGS x DATA_WIDTH register file, NUM_RD async read ports, one write port.
//  Write port overwrites or accumulates (psum RMW) in one clock; per-entry valid bits; multi-cycle bulk-clear FSM.
//  Sits in the Eyeriss PE as filter/ifmap/psum SPad. Psum instance uses accumulate mode; filter/ifmap use overwrite.
// PARAMETERS
//  DATA_WIDTH  16                  entry width, two's complement
//  NUM_REGS    24                  number of entries
//  NUM_RD      2                   number of read ports
//  ADDR_WIDTH  $clog2(NUM_REGS)    address width
// PORTS
//  clk     in   1                  clock, rising edge
//  rst     in   1                  asynchronous reset, active-high
//  en      in   1                  enable; gates new writes and clear start
//  wen     in   1                  write request
//  wmode   in   1                  0 = overwrite, 1 = accumulate (regs[waddr] + din)
//  waddr   in   ADDR_WIDTH         write address
//  din     in   DATA_WIDTH         write data
//  clr     in   1                  bulk-clear start (level sampled)
//  raddr   in   NUM_RD*ADDR_WIDTH  read addresses; port i = bits [i*ADDR_WIDTH +: ADDR_WIDTH]
//  dout    out  NUM_RD*DATA_WIDTH  read data, same packing as raddr
//  rvalid  out  NUM_RD             valid bit of addressed entry, per port
//  busy    out  1                  high while the clear FSM is in CLEAR
//  wr_drop out  1                  registered; pulses 1 cycle for each write request not performed
// BEHAVIOUR
//  Reset (async, rst=1): all entries 0, all valid 0, FSM IDLE, clear counter 0, busy=0, wr_drop=0.
//  Read: combinational. dout[i] = regs[raddr[i]]; rvalid[i] = valid[raddr[i]].
//   - raddr >= NUM_REGS: dout=0, rvalid=0.
//   - Same-cycle write to the read address: old value is read. New value is visible the cycle after the edge.
//  Write: accepted when en & wen & state==IDLE & !clr & waddr<NUM_REGS. Committed at that clock edge; valid[waddr]<=1.
//   - Overwrite: regs <= din.
//   - Accumulate: regs <= regs + din, DATA_WIDTH result (see CONFIGURATION).
//   - Back-to-back accumulates to the same address chain correctly (no stall, no hazard).
//  wr_drop <= 1 on the edge after any en&wen request that is not accepted:
//   - during CLEAR
//   - clr also asserted (clr wins)
//   - waddr out of range
//  FSM states
//   - IDLE: en&clr -> CLEAR, counter<=0.
//   - CLEAR: each cycle regs[counter]<=0, valid[counter]<=0, counter++.
//     After counter==NUM_REGS-1 is cleared -> IDLE.
//     Takes exactly NUM_REGS cycles with busy=1. clr and en are ignored in CLEAR; the clear always completes.
//   - Reads stay live during CLEAR: entries not yet cleared return their old data.
//  Reset mid-CLEAR aborts immediately to the reset state.
// CONFIGURATION
//  Macro SPAD_SAT_EN
//   - Defined: accumulate saturates to the signed range, 2^(DATA_WIDTH-1)-1 / -2^(DATA_WIDTH-1).
//   - Undefined: accumulate wraps modulo 2^DATA_WIDTH.
//  Overwrite mode is unaffected either way.
// STRUCTURE
//  Package reg_spad_pkg:
//   - wmode constants (WM_OVR=0, WM_ACC=1)
//   - FSM state encoding (ST_IDLE, ST_CLEAR)
//   - function sat_add(a,b) used under SPAD_SAT_EN
//  Sub-module spad_acc_adder: DATA_WIDTH adder, wrap or saturate selected by SPAD_SAT_EN. Combinational; one instance.
// TESTING
//  1. Reset, then read all addresses on both ports -> dout=0, rvalid=0.
//  2. Overwrite addr 3 = 0x0005, then accumulate 0x0007 twice on consecutive cycles -> addr 3 reads 0x0013, rvalid=1.
//  3. Set addr 0 = 0x7FFF, accumulate 0x0002 -> 0x7FFF with SPAD_SAT_EN, 0x8001 without.
//     Set addr 0 = 0x8000, accumulate 0xFFFF -> 0x8000 with SPAD_SAT_EN, 0x7FFF without.
//  4. Fill all 24 entries, pulse clr -> busy=1 for exactly 24 cycles; all valid=0 and all data 0 after.
//     A write issued mid-clear is not performed and wr_drop pulses next cycle.
//  5. Same cycle: write addr 5 = 0x00AA while port 0 reads addr 5 -> old value that cycle, 0x00AA next cycle.
//     Write with waddr=30 -> wr_drop=1 and no entry changes.
//  6. Assert rst asynchronously at clear cycle 10 -> all outputs 0 before the next edge.
//     Entries 10..23 zeroed, FSM IDLE.

Source files
------------

// File: rtl/reg_spad_pkg.sv
// Shared constants, FSM encoding and saturating-add helper for the PE scratch pad.
// sat_add is only referenced when SPAD_SAT_EN is defined.
package reg_spad_pkg;

    localparam logic WM_OVR = 1'b0;
    localparam logic WM_ACC = 1'b1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } spad_state_t;

    // Operands arrive sign-extended to 32 bits; result is clamped to a w-bit signed range.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input int unsigned w);
        logic signed [32:0] sum;
        logic signed [32:0] max_v;
        logic signed [32:0] min_v;
        sum   = $signed({a[31], a}) + $signed({b[31], b});
        max_v = (33'sd1 <<< (w - 1)) - 33'sd1;
        min_v = -(33'sd1 <<< (w - 1));
        if (sum > max_v)
            return max_v[31:0];
        else if (sum < min_v)
            return min_v[31:0];
        else
            return sum[31:0];
    endfunction

endpackage

// File: rtl/spad_acc_adder.sv
// Accumulate adder for the scratch pad write port.
// SPAD_SAT_EN selects signed saturation; otherwise the sum wraps modulo 2^DATA_WIDTH.
module spad_acc_adder
    import reg_spad_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] sum
);

`ifdef SPAD_SAT_EN
    localparam int EXT = 32 - DATA_WIDTH;

    logic [31:0] a_ext;
    logic [31:0] b_ext;
    logic [31:0] s_ext;

    assign a_ext = {{EXT{a[DATA_WIDTH-1]}}, a};
    assign b_ext = {{EXT{b[DATA_WIDTH-1]}}, b};
    assign s_ext = sat_add(a_ext, b_ext, DATA_WIDTH);
    assign sum   = s_ext[DATA_WIDTH-1:0];
`else
    assign sum = a + b;
`endif

endmodule

// File: rtl/reg_spad_acc_mp.sv
// PE scratch pad: multi-port async read, single overwrite/accumulate write port, bulk clear FSM.
// Build option: define SPAD_SAT_EN for saturating accumulate (default wraps).
module reg_spad_acc_mp
    import reg_spad_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 24,
    parameter int NUM_RD     = 2,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         wen,
    input  logic                         wmode,
    input  logic [ADDR_WIDTH-1:0]        waddr,
    input  logic [DATA_WIDTH-1:0]        din,
    input  logic                         clr,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0] dout,
    output logic [NUM_RD-1:0]            rvalid,
    output logic                         busy,
    output logic                         wr_drop
);

    // One extra bit so the limit is representable even when NUM_REGS is a power of two.
    localparam logic [ADDR_WIDTH:0]   REGS_LIM = (ADDR_WIDTH + 1)'(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   valid_reg;

    spad_state_t           state_reg, state_next;
    logic [ADDR_WIDTH-1:0] cnt_reg, cnt_next;
    logic                  wr_drop_reg;

    logic                  wr_req;
    logic                  waddr_ok;
    logic                  wr_accept;
    logic [DATA_WIDTH-1:0] wr_old;
    logic [DATA_WIDTH-1:0] acc_sum;
    logic [DATA_WIDTH-1:0] wr_data;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_WIDTH-1:0] ra;
            logic                  ra_ok;
            assign ra    = raddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign ra_ok = {1'b0, ra} < REGS_LIM;
            assign dout[gi*DATA_WIDTH +: DATA_WIDTH] = ra_ok ? regs[ra] : '0;
            assign rvalid[gi] = ra_ok ? valid_reg[ra] : 1'b0;
        end
    endgenerate

    assign wr_req    = en & wen;
    assign waddr_ok  = {1'b0, waddr} < REGS_LIM;
    assign wr_accept = wr_req & (state_reg == ST_IDLE) & ~clr & waddr_ok;
    assign wr_old    = waddr_ok ? regs[waddr] : '0;

    spad_acc_adder #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_adder (
        .a  (wr_old),
        .b  (din),
        .sum(acc_sum)
    );

    assign wr_data = (wmode == WM_ACC) ? acc_sum : din;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (en && clr) begin
                    state_next = ST_CLEAR;
                    cnt_next   = '0;
                end
            end
            ST_CLEAR: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == LAST_IDX) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            wr_drop_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            wr_drop_reg <= wr_req & ~wr_accept;
        end
    end

    // Clear and write are mutually exclusive: writes are only accepted in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
            valid_reg <= '0;
        end else if (state_reg == ST_CLEAR) begin
            regs[cnt_reg]      <= '0;
            valid_reg[cnt_reg] <= 1'b0;
        end else if (wr_accept) begin
            regs[waddr]      <= wr_data;
            valid_reg[waddr] <= 1'b1;
        end
    end

    assign busy    = (state_reg == ST_CLEAR);
    assign wr_drop = wr_drop_reg;

endmodule

// File: tb/tb_reg_spad_acc_mp.sv
// Randomized + directed bench for reg_spad_acc_mp against an array-based reference model.
// Honors SPAD_SAT_EN for the expected accumulate results.
module tb_reg_spad_acc_mp;

    localparam int DW = 16;
    localparam int NR = 24;
    localparam int RD = 2;
    localparam int AW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            en, wen, wmode, clr;
    logic [AW-1:0]   waddr;
    logic [DW-1:0]   din;
    logic [RD*AW-1:0] raddr;
    logic [RD*DW-1:0] dout;
    logic [RD-1:0]   rvalid;
    logic            busy, wr_drop;

    reg_spad_acc_mp #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_RD(RD), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .en(en), .wen(wen), .wmode(wmode), .waddr(waddr),
        .din(din), .clr(clr), .raddr(raddr), .dout(dout), .rvalid(rvalid),
        .busy(busy), .wr_drop(wr_drop)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: contents, valid flags, clear progress, registered drop flag
    logic [DW-1:0] m_data [NR];
    logic          m_valid [NR];
    int            m_clr_left;
    int            m_clr_idx;
    logic          m_drop;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] acc_ref(input logic [DW-1:0] o, input logic [DW-1:0] d);
        int s;
        s = int'($signed(o)) + int'($signed(d));
`ifdef SPAD_SAT_EN
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`endif
        return s[DW-1:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_data[i]  = '0;
            m_valid[i] = 1'b0;
        end
        m_clr_left = 0;
        m_clr_idx  = 0;
        m_drop     = 1'b0;
    endtask

    task automatic drive(input logic e, input logic w, input logic m, input int a,
                         input logic [DW-1:0] d, input logic c);
        en = e; wen = w; wmode = m; waddr = AW'(a); din = d; clr = c;
    endtask

    task automatic set_rd(input int a0, input int a1);
        raddr = {AW'(a1), AW'(a0)};
    endtask

    // Called just after a falling edge with inputs driven: check outputs, advance model one cycle.
    task automatic step();
        int a;
        logic nd;
        #1;
        for (int p = 0; p < RD; p++) begin
            a = int'(raddr[p*AW +: AW]);
            chk($sformatf("rd%0d_data@%0d", p, a), 32'(dout[p*DW +: DW]), (a < NR) ? 32'(m_data[a]) : 32'd0);
            chk($sformatf("rd%0d_valid@%0d", p, a), 32'(rvalid[p]), (a < NR) ? 32'(m_valid[a]) : 32'd0);
        end
        chk("busy", 32'(busy), 32'(m_clr_left > 0));
        chk("wr_drop", 32'(wr_drop), 32'(m_drop));
        nd = 1'b0;
        if (m_clr_left > 0) begin
            m_data[m_clr_idx]  = '0;
            m_valid[m_clr_idx] = 1'b0;
            m_clr_idx++;
            m_clr_left--;
            if (en && wen) nd = 1'b1;
        end else if (en && clr) begin
            m_clr_left = NR;
            m_clr_idx  = 0;
            if (wen) nd = 1'b1;
        end else if (en && wen) begin
            if (int'(waddr) < NR) begin
                m_data[waddr]  = wmode ? acc_ref(m_data[waddr], din) : din;
                m_valid[waddr] = 1'b1;
            end else begin
                nd = 1'b1;
            end
        end
        m_drop = nd;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_in();
        drive(1'b0, 1'b0, 1'b0, 0, '0, 1'b0);
    endtask

    initial begin
        int busy_cnt;
        int guard;
        rst = 1'b1;
        idle_in();
        set_rd(0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1. Reset state on every address, both ports
        for (int i = 0; i < 32; i++) begin
            set_rd(i, 31 - i);
            step();
        end

        // 2. Overwrite then back-to-back accumulate
        set_rd(3, 3);
        drive(1, 1, 0, 3, 16'h0005, 0); step();
        drive(1, 1, 1, 3, 16'h0007, 0); step();
        drive(1, 1, 1, 3, 16'h0007, 0); step();
        idle_in(); #1;
        chk("acc_chain", 32'(dout[DW-1:0]), 32'h0013);
        chk("acc_chain_valid", 32'(rvalid[0]), 32'd1);
        step();

        // 3. Accumulate overflow boundaries
        set_rd(0, 1);
        drive(1, 1, 0, 0, 16'h7FFF, 0); step();
        drive(1, 1, 1, 0, 16'h0002, 0); step();
        idle_in(); #1;
`ifdef SPAD_SAT_EN
        chk("acc_pos_ovf", 32'(dout[DW-1:0]), 32'h7FFF);
`else
        chk("acc_pos_ovf", 32'(dout[DW-1:0]), 32'h8001);
`endif
        step();
        drive(1, 1, 0, 0, 16'h8000, 0); step();
        drive(1, 1, 1, 0, 16'hFFFF, 0); step();
        idle_in(); #1;
`ifdef SPAD_SAT_EN
        chk("acc_neg_ovf", 32'(dout[DW-1:0]), 32'h8000);
`else
        chk("acc_neg_ovf", 32'(dout[DW-1:0]), 32'h7FFF);
`endif
        step();

        // 4. Fill, bulk clear with a dropped mid-clear write
        for (int i = 0; i < NR; i++) begin
            drive(1, 1, 0, i, 16'($urandom_range(1, 16'hFFFF)), 0);
            set_rd(i, NR - 1 - i);
            step();
        end
        drive(1, 0, 0, 0, '0, 1); step();
        busy_cnt = 0;
        guard = 0;
        idle_in();
        #1;
        while (busy && guard < 60) begin
            busy_cnt++;
            guard++;
            if (busy_cnt == 6) drive(1, 1, 0, 2, 16'h1234, 0);
            else idle_in();
            set_rd(busy_cnt % NR, 2);
            step();
            #1;
        end
        chk("clear_cycles", 32'(busy_cnt), 32'(NR));
        for (int i = 0; i < NR; i++) begin
            set_rd(i, i);
            #1;
            chk("post_clr_valid", 32'(rvalid[0]), 32'd0);
            step();
        end

        // 5. Read-during-write and out-of-range write
        set_rd(5, 6);
        drive(1, 1, 0, 5, 16'h0011, 0); step();
        drive(1, 1, 0, 5, 16'h00AA, 0); #1;
        chk("rdw_old", 32'(dout[DW-1:0]), 32'h0011);
        step();
        idle_in(); #1;
        chk("rdw_new", 32'(dout[DW-1:0]), 32'h00AA);
        step();
        drive(1, 1, 0, 30, 16'hBEEF, 0); step();
        idle_in(); #1;
        chk("oor_drop", 32'(wr_drop), 32'd1);
        for (int i = 0; i < 32; i += 2) begin
            set_rd(i, i + 1);
            step();
        end

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 9) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
                  ($urandom_range(0, 7) == 0) ? $urandom_range(24, 31) : $urandom_range(0, 23),
                  16'($urandom), ($urandom_range(0, 59) == 0));
            set_rd($urandom_range(0, 31), $urandom_range(0, 31));
            step();
        end
        idle_in();
        guard = 0;
        while (m_clr_left > 0 && guard < 40) begin
            guard++;
            step();
        end

        // 6. Async reset mid-clear
        for (int i = 0; i < NR; i++) begin
            drive(1, 1, 0, i, 16'h0100 + 16'(i), 0);
            step();
        end
        drive(1, 0, 0, 0, '0, 1); step();
        idle_in();
        for (int i = 0; i < 10; i++) step();
        set_rd(15, 20);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_dout", 32'(dout), 32'd0);
        chk("arst_rvalid", 32'(rvalid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_drop", 32'(wr_drop), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NR; i++) begin
            set_rd(i, NR - 1 - i);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
